lp_feeder: RTL and testbench
============================

# lp_feeder

Stimulus-side transmitter for the 2-variable integer LP solver interface. A host loads one objective and six constraint rows into a local register file. On `start`, the block checks that the problem is bounded, then streams it as a 7-beat `in_valid` burst to the solver. It then waits for the solver's single-cycle result strobe and returns the captured maximum, or a timeout or error status, to the host.

## Interface
Parameters:
- `TIMEOUT`, default 1048576: maximum number of WAIT cycles allowed for the result before the block aborts.
- `TW`, default 25: width of the wait counter. Must satisfy 2^TW > `TIMEOUT`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  host write strobe for the register file.
- `ld_addr`  in  3  0 selects the objective (c1, c2). 1–6 select constraint rows. 7 is ignored.
- `ld_a1`, `ld_a2`  in  6 each  signed coefficients.
- `ld_b`  in  12  signed right-hand side. Ignored when `ld_addr` = 0.
- `start`  in  1  single-cycle request to send the loaded problem.
- `in_valid`  out  1  burst valid to the solver.
- `in_a1`, `in_a2`  out  6 each  signed beat payload to the solver.
- `in_b`  out  12  signed beat payload to the solver.
- `sol_valid`  in  1  solver result strobe.
- `sol_value`  in  12  signed solver maximum.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  12  signed captured result. Held until the next `done`.
- `err`  out  1  valid with `done`: the problem is unbounded or malformed.
- `timeout`  out  1  valid with `done`: no result arrived.

## Operation
- Register file: 7 entries (a1, a2, b).
  - Written only in IDLE, when `ld_valid` = 1 and `ld_addr` ≤ 6.
  - Writes in any other state are dropped.
  - Contents survive across problems. Reset clears all entries to 0.
- FSM states: IDLE → CHECK → SEND → WAIT → FIN → IDLE.
  - IDLE: on `start`, go to CHECK. `start` outside IDLE is ignored.
  - If `ld_valid` and `start` arrive in the same IDLE cycle, the write lands first and CHECK sees the new data.
  - CHECK (1 cycle): scan rows 1–6 for the four bound patterns (1,0), (−1,0), (0,1), (0,−1).
    - If several rows match a pattern, the highest-numbered matching row is the one used.
    - Bounded means all four patterns are present, b(1,0) + b(−1,0) ≥ 0, and b(0,1) + b(0,−1) ≥ 0.
    - Sums are evaluated at 13 bits signed.
    - Bounded: go to SEND. Otherwise: set err, go to FIN.
  - SEND (7 cycles): beat k (k = 0..6) drives entry k on `in_a1`/`in_a2`/`in_b` with `in_valid` = 1.
    - Beat 0 drives `in_b` = 0.
    - After beat 6, go to WAIT.
  - WAIT: the counter starts at 0 and increments every cycle.
    - `sol_valid` = 1: capture `sol_value` into `result`, go to FIN.
    - Else, if the counter reaches `TIMEOUT` − 1: set timeout, load `result` = −2048 (12'h800), go to FIN.
    - If `sol_valid` arrives in the same cycle the counter hits its limit, `sol_valid` wins.
  - FIN (1 cycle): `done` = 1, with `err`/`timeout` valid. Then go to IDLE.
- `sol_valid` outside WAIT is ignored.
- `result` is unchanged on `err`.
- When `in_valid` = 0, `in_a1`/`in_a2`/`in_b` drive 0.

## Timing
- Reset values: `in_valid` = 0; `in_a1`/`in_a2`/`in_b` = 0; `busy` = 0; `done` = 0; `result` = 0; `err` = 0; `timeout` = 0. FSM = IDLE, counter = 0.
- Reset mid-burst: `in_valid` drops asynchronously. After reset the solver sees a truncated burst; re-driving it is the host's job.
- Normal run, with `start` sampled at edge T:
  - CHECK at T+1.
  - `in_valid` high for cycles T+2..T+8.
  - WAIT from T+9.
  - `sol_valid` at cycle W gives `done` at W+1.
  - `busy` is high from T+1 through the FIN cycle inclusive.
- Error run: `done` and `err` at T+2. No `in_valid` is ever asserted.
- `err` and `timeout` are cleared when leaving IDLE on `start`, and held after FIN until the next `start`.
- Back-to-back operation: the earliest next `start` is accepted in the cycle after FIN. This guarantees at least 2 idle cycles of `in_valid` between bursts.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Box problem:
  - Load c = (1,1) and rows (1,0,5), (−1,0,0), (0,1,3), (0,−1,0), (1,1,6), (1,1,100).
  - Stub solver answers 6 at WAIT cycle 40.
  - Required: exactly 7 beats in order; `result` = 6; `done` pulse 1 cycle; `err` = 0, `timeout` = 0.
- Missing bound: replace row 4 with (1,1,100), then `start`.
  - Required: `done` and `err` at T+2; `in_valid` never high.
- Inverted bounds: rows (1,0,−3) and (−1,0,1), with the y-bounds valid.
  - Sum −2 < 0, so required: `err` = 1.
- Timeout: with `TIMEOUT` = 16, the stub never answers.
  - Required: `done` and `timeout` at WAIT count 15; `result` = −2048.
- Races:
  - `sol_valid` on the same cycle as the timeout limit: required `result` = `sol_value`, `timeout` = 0.
  - `ld_valid` to row 2 during SEND: required write dropped, re-read on the next run unchanged.
  - `start` during WAIT: required ignored.
- Async reset asserted at the 4th beat: required `in_valid`, `busy` and `result` are 0 immediately. A fresh `start` after release transmits the full 7 beats.

Source files
------------

// File: rtl/lp_feeder.sv
// Host-side feeder for the 2-variable integer LP solver: holds one problem,
// checks it is bounded, streams it as a 7-beat burst and returns the solver result.
module lp_feeder #(
    parameter int TIMEOUT = 1048576,
    parameter int TW      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_valid,
    input  logic        [2:0]  ld_addr,
    input  logic signed [5:0]  ld_a1,
    input  logic signed [5:0]  ld_a2,
    input  logic signed [11:0] ld_b,
    input  logic               start,
    output logic               in_valid,
    output logic signed [5:0]  in_a1,
    output logic signed [5:0]  in_a2,
    output logic signed [11:0] in_b,
    input  logic               sol_valid,
    input  logic signed [11:0] sol_value,
    output logic               busy,
    output logic               done,
    output logic signed [11:0] result,
    output logic               err,
    output logic               timeout
);

    typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT, FIN} state_t;

    localparam logic signed [5:0]  C_ONE  = 6'sd1;
    localparam logic signed [5:0]  C_NEG  = -6'sd1;
    localparam logic signed [5:0]  C_ZERO = 6'sd0;
    localparam logic signed [11:0] R_TMO  = -12'sd2048;
    localparam logic [TW-1:0]      CNT_LAST = TW'(TIMEOUT - 1);

    state_t             state, nstate;
    logic        [2:0]  beat, nbeat;
    logic [TW-1:0]      cnt, ncnt;
    logic signed [11:0] nxt_result;
    logic               nxt_err, nxt_timeout;

    // Entry 7 is never written and stays zero.
    logic signed [5:0]  rf_a1 [0:7];
    logic signed [5:0]  rf_a2 [0:7];
    logic signed [11:0] rf_b  [0:7];

    logic               found_px, found_nx, found_py, found_ny;
    logic signed [11:0] b_px, b_nx, b_py, b_ny;
    logic               bounded;

    // Opposing bounds are consistent when their right-hand sides sum to >= 0 at 13 bits.
    function automatic logic pair_ok(input logic signed [11:0] x, input logic signed [11:0] y);
        logic signed [12:0] s;
        s = $signed({x[11], x}) + $signed({y[11], y});
        return !s[12];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_a1[i] <= '0;
                rf_a2[i] <= '0;
                rf_b[i]  <= '0;
            end
        end else if (state == IDLE && ld_valid && ld_addr != 3'd7) begin
            rf_a1[ld_addr] <= ld_a1;
            rf_a2[ld_addr] <= ld_a2;
            if (ld_addr != 3'd0)
                rf_b[ld_addr] <= ld_b;
        end
    end

    // Ascending scan so the highest-numbered matching row wins.
    always_comb begin
        found_px = 1'b0; found_nx = 1'b0; found_py = 1'b0; found_ny = 1'b0;
        b_px = '0; b_nx = '0; b_py = '0; b_ny = '0;
        for (int i = 1; i <= 6; i++) begin
            if (rf_a1[i] == C_ONE && rf_a2[i] == C_ZERO) begin found_px = 1'b1; b_px = rf_b[i]; end
            if (rf_a1[i] == C_NEG && rf_a2[i] == C_ZERO) begin found_nx = 1'b1; b_nx = rf_b[i]; end
            if (rf_a1[i] == C_ZERO && rf_a2[i] == C_ONE) begin found_py = 1'b1; b_py = rf_b[i]; end
            if (rf_a1[i] == C_ZERO && rf_a2[i] == C_NEG) begin found_ny = 1'b1; b_ny = rf_b[i]; end
        end
        bounded = found_px && found_nx && found_py && found_ny &&
                  pair_ok(b_px, b_nx) && pair_ok(b_py, b_ny);
    end

    always_comb begin
        nstate      = state;
        nbeat       = beat;
        ncnt        = cnt;
        nxt_result  = result;
        nxt_err     = err;
        nxt_timeout = timeout;
        case (state)
            IDLE: begin
                if (start) begin
                    nstate      = CHECK;
                    nxt_err     = 1'b0;
                    nxt_timeout = 1'b0;
                end
            end
            CHECK: begin
                if (bounded) begin
                    nstate = SEND;
                    nbeat  = 3'd0;
                end else begin
                    nstate  = FIN;
                    nxt_err = 1'b1;
                end
            end
            SEND: begin
                if (beat == 3'd6) begin
                    nstate = WAIT;
                    ncnt   = '0;
                end else begin
                    nbeat = beat + 3'd1;
                end
            end
            WAIT: begin
                if (sol_valid) begin
                    nstate     = FIN;
                    nxt_result = sol_value;
                end else if (cnt == CNT_LAST) begin
                    nstate      = FIN;
                    nxt_timeout = 1'b1;
                    nxt_result  = R_TMO;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Outputs are loaded from next-state values so every port comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            cnt      <= '0;
            in_valid <= 1'b0;
            in_a1    <= '0;
            in_a2    <= '0;
            in_b     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= nstate;
            beat     <= nbeat;
            cnt      <= ncnt;
            in_valid <= (nstate == SEND);
            in_a1    <= (nstate == SEND) ? rf_a1[nbeat] : '0;
            in_a2    <= (nstate == SEND) ? rf_a2[nbeat] : '0;
            in_b     <= (nstate == SEND && nbeat != 3'd0) ? rf_b[nbeat] : '0;
            busy     <= (nstate != IDLE);
            done     <= (nstate == FIN);
            result   <= nxt_result;
            err      <= nxt_err;
            timeout  <= nxt_timeout;
        end
    end

endmodule

// File: tb/tb_lp_feeder.sv
// Directed bench for lp_feeder: default-timeout instance for normal runs and a
// TIMEOUT=16 instance for the timeout limit and its sol_valid race.
module tb_lp_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ld_valid, start, start16, sol_valid, sol_valid16;
    logic [2:0]  ld_addr;
    logic [5:0]  ld_a1, ld_a2;
    logic [11:0] ld_b, sol_value;

    logic        in_valid, busy, done, err, timeout;
    logic [5:0]  in_a1, in_a2;
    logic [11:0] in_b, result;
    logic        in_valid16, busy16, done16, err16, timeout16;
    logic [5:0]  in_a1_16, in_a2_16;
    logic [11:0] in_b16, result16;

    lp_feeder u_dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_a1(ld_a1), .ld_a2(ld_a2), .ld_b(ld_b), .start(start),
        .in_valid(in_valid), .in_a1(in_a1), .in_a2(in_a2), .in_b(in_b),
        .sol_valid(sol_valid), .sol_value(sol_value), .busy(busy), .done(done),
        .result(result), .err(err), .timeout(timeout)
    );

    lp_feeder #(.TIMEOUT(16), .TW(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_a1(ld_a1), .ld_a2(ld_a2), .ld_b(ld_b), .start(start16),
        .in_valid(in_valid16), .in_a1(in_a1_16), .in_a2(in_a2_16), .in_b(in_b16),
        .sol_valid(sol_valid16), .sol_value(sol_value), .busy(busy16), .done(done16),
        .result(result16), .err(err16), .timeout(timeout16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nb = 0, ndone = 0, done_cyc = -1;
    int          nb16 = 0, ndone16 = 0, done_cyc16 = -1;
    logic [23:0] beat_log [0:127];
    int          beat_cyc [0:127];
    logic [23:0] last16;
    logic        d_err, d_to, d_err16, d_to16;
    logic [11:0] d_res, d_res16;

    always @(negedge clk) begin
        if (in_valid && nb < 128) begin
            beat_log[nb] = {in_a1, in_a2, in_b};
            beat_cyc[nb] = cyc;
            nb++;
        end
        if (done) begin
            ndone++; done_cyc = cyc; d_err = err; d_to = timeout; d_res = result;
        end
        if (in_valid16) begin
            nb16++; last16 = {in_a1_16, in_a2_16, in_b16};
        end
        if (done16) begin
            ndone16++; done_cyc16 = cyc; d_err16 = err16; d_to16 = timeout16; d_res16 = result16;
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int a1, input int a2, input int b);
        return {a1[5:0], a2[5:0], b[11:0]};
    endfunction

    task automatic wait_to(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic ld(input int addr, input int a1, input int a2, input int b);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = addr[2:0]; ld_a1 = a1[5:0]; ld_a2 = a2[5:0]; ld_b = b[11:0];
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic go(output int t0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; t0 = cyc; start = 1'b0;
    endtask

    task automatic go16(output int t0);
        @(negedge clk); start16 = 1'b1;
        @(posedge clk); #1; t0 = cyc; start16 = 1'b0;
    endtask

    task automatic load_box();
        ld(0, 1, 1, 0);  ld(1, 1, 0, 5);  ld(2, -1, 0, 0); ld(3, 0, 1, 3);
        ld(4, 0, -1, 0); ld(5, 1, 1, 6);  ld(6, 1, 1, 100);
    endtask

    logic [23:0] box_exp [0:6];
    int t0, nb0, nd0, nd16;

    initial begin
        box_exp[0] = pk(1, 1, 0);  box_exp[1] = pk(1, 0, 5);  box_exp[2] = pk(-1, 0, 0);
        box_exp[3] = pk(0, 1, 3);  box_exp[4] = pk(0, -1, 0); box_exp[5] = pk(1, 1, 6);
        box_exp[6] = pk(1, 1, 100);
        rst_n = 1'b0; ld_valid = 1'b0; start = 1'b0; start16 = 1'b0;
        sol_valid = 1'b0; sol_valid16 = 1'b0;
        ld_addr = '0; ld_a1 = '0; ld_a2 = '0; ld_b = '0; sol_value = '0;
        repeat (3) @(negedge clk);
        check("rst_in_valid", in_valid, 0);
        check("rst_payload", {in_a1, in_a2, in_b}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // Box problem, solver answers 6 at WAIT count 40
        load_box();
        nb0 = nb; nd0 = ndone;
        go(t0);
        check("box_busy_check", {busy, in_valid}, 2'b10);
        wait_to(t0 + 48); sol_value = 12'd6; sol_valid = 1'b1;
        wait_to(t0 + 49); sol_valid = 1'b0;
        wait_to(t0 + 52);
        check("box_nbeats", nb - nb0, 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("box_beat%0d", k), beat_log[nb0 + k], box_exp[k]);
            check($sformatf("box_beat%0d_cyc", k), beat_cyc[nb0 + k] - t0, k + 1);
        end
        check("box_done_cyc", done_cyc - t0, 49);
        check("box_done_pulses", ndone - nd0, 1);
        check("box_result", d_res, 12'd6);
        check("box_err_to", {d_err, d_to}, 2'b00);
        check("box_idle_after", {busy, result}, {1'b0, 12'd6});

        // Timeout limit on the TIMEOUT=16 instance
        nd16 = ndone16; nb0 = nb16;
        go16(t0);
        wait_to(t0 + 27);
        check("tmo_done_cyc", done_cyc16 - t0, 24);
        check("tmo_done_pulses", ndone16 - nd16, 1);
        check("tmo_flags", {d_err16, d_to16}, 2'b01);
        check("tmo_result", d_res16, 12'h800);
        check("tmo_beats", nb16 - nb0, 7);
        check("tmo_last_beat", last16, pk(1, 1, 100));
        check("tmo_busy_after", busy16, 0);

        // sol_valid on the limit cycle wins
        go16(t0);
        check("race_tmo_cleared", timeout16, 0);
        wait_to(t0 + 23); sol_value = 12'd77; sol_valid16 = 1'b1;
        wait_to(t0 + 24); sol_valid16 = 1'b0;
        wait_to(t0 + 27);
        check("race_done_cyc", done_cyc16 - t0, 24);
        check("race_result", d_res16, 12'd77);
        check("race_timeout", d_to16, 0);

        // Load during SEND dropped, start during WAIT ignored
        nb0 = nb; nd0 = ndone;
        go(t0);
        wait_to(t0 + 3);
        ld_valid = 1'b1; ld_addr = 3'd2; ld_a1 = 6'd5; ld_a2 = 6'd5; ld_b = 12'd50;
        wait_to(t0 + 4); ld_valid = 1'b0;
        wait_to(t0 + 12); start = 1'b1;
        wait_to(t0 + 13); start = 1'b0;
        wait_to(t0 + 18); sol_value = 12'hFFB; sol_valid = 1'b1;
        wait_to(t0 + 19); sol_valid = 1'b0;
        wait_to(t0 + 25);
        check("wstart_done_cyc", done_cyc - t0, 19);
        check("wstart_done_pulses", ndone - nd0, 1);
        check("wstart_beats", nb - nb0, 7);
        check("wstart_result", d_res, 12'hFFB);
        check("wstart_idle", busy, 0);
        nb0 = nb;
        go(t0);
        wait_to(t0 + 8); sol_value = 12'd9; sol_valid = 1'b1;
        wait_to(t0 + 9); sol_valid = 1'b0;
        wait_to(t0 + 11);
        check("ldrop_beats", nb - nb0, 7);
        check("ldrop_row2", beat_log[nb0 + 2], pk(-1, 0, 0));
        check("ldrop_result", d_res, 12'd9);

        // Missing (0,-1) bound
        ld(4, 1, 1, 100);
        nb0 = nb; nd0 = ndone;
        go(t0);
        wait_to(t0 + 4);
        check("miss_done_cyc", done_cyc - t0, 1);
        check("miss_flags", {d_err, d_to}, 2'b10);
        check("miss_no_beats", nb - nb0, 0);
        check("miss_result_kept", result, 12'd9);
        check("miss_err_held", {err, busy}, 2'b10);

        // Inverted x bounds: 1 + (-3) < 0
        ld(4, 0, -1, 0); ld(1, 1, 0, -3); ld(2, -1, 0, 1);
        nb0 = nb;
        go(t0);
        wait_to(t0 + 4);
        check("inv_done_cyc", done_cyc - t0, 1);
        check("inv_err", d_err, 1);
        check("inv_no_beats", nb - nb0, 0);

        // -2048 + -2048 must not wrap to a non-negative sum
        ld(1, 1, 0, -2048); ld(2, -1, 0, -2048);
        go(t0);
        wait_to(t0 + 4);
        check("ovf_err", {d_err, done_cyc - t0 == 1}, 2'b11);

        // Sum exactly zero is bounded; err clears on start
        ld(1, 1, 0, -1); ld(2, -1, 0, 1);
        nb0 = nb;
        go(t0);
        check("zero_err_cleared", err, 0);
        wait_to(t0 + 8); sol_value = 12'd3; sol_valid = 1'b1;
        wait_to(t0 + 9); sol_valid = 1'b0;
        wait_to(t0 + 11);
        check("zero_beats", nb - nb0, 7);
        check("zero_done", {d_err, d_to, d_res}, {2'b00, 12'd3});

        // Async reset at the 4th beat
        ld(1, 1, 0, 5); ld(2, -1, 0, 0);
        nb0 = nb;
        go(t0);
        wait_to(t0 + 4); #2;
        rst_n = 1'b0; #1;
        check("arst_in_valid", in_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_partial", nb - nb0, 4);
        @(negedge clk); rst_n = 1'b1;
        load_box();
        nb0 = nb;
        go(t0);
        wait_to(t0 + 8); sol_value = 12'd6; sol_valid = 1'b1;
        wait_to(t0 + 9); sol_valid = 1'b0;
        wait_to(t0 + 11);
        check("arst_full_burst", nb - nb0, 7);
        check("arst_last_beat", beat_log[nb0 + 6], pk(1, 1, 100));
        check("arst_result2", d_res, 12'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
